// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shared 64-bit shift datapath,
// 32 iterations per operation, single-cycle registered writeback strobe.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  localparam int unsigned DW    = 2 * XLEN;
  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [DW-1:0]     acc_q, acc_d;
  logic              busy_q, busy_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;

  // Operand classification at accept time
  logic            sgn_a_c, sgn_b_c, neg_a_c, neg_b_c;
  logic [XLEN-1:0] mag_a_c, mag_b_c;
  logic            div0_c, ovf_c;

  always_comb begin
    sgn_a_c = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    sgn_b_c = funct3[2] ? ~funct3[0] : ~funct3[1];
    neg_a_c = sgn_a_c & rs1_data[XLEN-1];
    neg_b_c = sgn_b_c & rs2_data[XLEN-1];
    mag_a_c = neg_a_c ? (~rs1_data + XLEN'(1)) : rs1_data;
    mag_b_c = neg_b_c ? (~rs2_data + XLEN'(1)) : rs2_data;
    div0_c  = funct3[2] && (rs2_data == '0);
    ovf_c   = funct3[2] && !funct3[0] &&
              (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
  end

  // One iteration of shift-add multiply (LSB first) or restoring divide (MSB first)
  logic [XLEN:0]   mul_sum_c;
  logic [DW-1:0]   mul_next_c;
  logic [XLEN:0]   div_pr_c;
  logic [XLEN+1:0] div_diff_c;
  logic            div_qbit_c;
  logic [XLEN-1:0] div_rem_c;
  logic [DW-1:0]   div_next_c;

  always_comb begin
    mul_sum_c  = {1'b0, acc_q[DW-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_next_c = {mul_sum_c, acc_q[XLEN-1:1]};
    div_pr_c   = {acc_q[DW-1:XLEN], acc_q[XLEN-1]};
    div_diff_c = {1'b0, div_pr_c} - {2'b00, opnd_q};
    div_qbit_c = ~div_diff_c[XLEN+1];
    div_rem_c  = div_qbit_c ? div_diff_c[XLEN-1:0] : div_pr_c[XLEN-1:0];
    div_next_c = {div_rem_c, acc_q[XLEN-2:0], div_qbit_c};
  end

  // Sign fix-up and result selection used in DONE
  logic [DW-1:0]   prod_c;
  logic [XLEN-1:0] quo_c, rem_c, result_c;

  always_comb begin
    prod_c = (neg_a_q ^ neg_b_q) ? (~acc_q + DW'(1)) : acc_q;
    quo_c  = (neg_a_q ^ neg_b_q) ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
    rem_c  = neg_a_q ? (~acc_q[DW-1:XLEN] + XLEN'(1)) : acc_q[DW-1:XLEN];
    if (special_q)         result_c = acc_q[XLEN-1:0];
    else if (!op_q[2])     result_c = (op_q[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[DW-1:XLEN];
    else if (!op_q[1])     result_c = quo_c;
    else                   result_c = rem_c;
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    rd_d       = rd_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    special_d  = special_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d      = funct3;
          rd_d      = rd_in;
          neg_a_d   = neg_a_c;
          neg_b_d   = neg_b_c;
          cnt_d     = '0;
          special_d = 1'b0;
          if (div0_c) begin
            special_d = 1'b1;
            acc_d     = {{XLEN{1'b0}}, (funct3[1] ? rs1_data : {XLEN{1'b1}})};
            state_d   = DONE;
          end else if (ovf_c) begin
            special_d = 1'b1;
            acc_d     = {{XLEN{1'b0}}, (funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}})};
            state_d   = DONE;
          end else if (funct3[2]) begin
            opnd_d  = mag_b_c;
            acc_d   = {{XLEN{1'b0}}, mag_a_c};
            state_d = CALC;
          end else begin
            opnd_d  = mag_a_c;
            acc_d   = {{XLEN{1'b0}}, mag_b_c};
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = op_q[2] ? div_next_c : mul_next_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!flush) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = result_c;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      special_q  <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      special_q  <= special_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign busy     = busy_q;
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, expected results
// and writeback cycle queued at issue, checked by an independent monitor.
module tb_muldiv_unit;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fails = 0;
  logic [31:0] last_data = 32'h0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .flush    (flush),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .busy     (busy),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every writeback strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_wb: got rd=%0d data=0x%08h, expected no writeback", wb_rd, wb_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_data", wb_data, e.data);
        check("wb_rd", 32'(wb_rd), 32'(e.rd));
        check("wb_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Present one request for one cycle; optionally queue its expected result.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_data, input int lat,
                       input bit push);
    exp_t e;
    start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd;
    if (push) begin
      e.rd = rd; e.data = exp_data; e.cyc = cyc + 1 + lat;
      sb.push_back(e);
      last_data = exp_data;
    end
    @(negedge clk);
    start = 1'b0; rs1_data = $urandom; rs2_data = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 100 && busy; i++) @(negedge clk);
    if (busy) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s_timeout: busy still 1 after 100 cycles, expected 0", name);
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp_data, input int lat);
    @(negedge clk);
    issue(f, a, b, rd, exp_data, lat, 1'b1);
    check("busy_after_accept", 32'(busy), 32'd1);
    wait_idle("run");
  endtask

  initial begin
    int i;
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0;
    rs1_data = '0; rs2_data = '0; rd_in = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Main function: multiply flavours
    run(MUL,    32'd7,         32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 33);
    run(MULH,   32'h80000000,  32'h80000000, 5'd4,  32'h40000000, 33);
    run(MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 33);
    run(MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 33);
    run(MUL,    32'h12345678,  32'h00000010, 5'd0,  32'h23456780, 33);
    // Divide flavours
    run(DIV,    32'hFFFFFFF9,  32'd2,        5'd7,  32'hFFFFFFFD, 33);
    run(REM,    32'hFFFFFFF9,  32'd2,        5'd8,  32'hFFFFFFFF, 33);
    run(DIVU,   32'd100,       32'd7,        5'd9,  32'd14,       33);
    run(REMU,   32'd100,       32'd7,        5'd10, 32'd2,        33);
    run(DIV,    32'd100,       32'hFFFFFFF9, 5'd11, 32'hFFFFFFF2, 33);
    run(REM,    32'd100,       32'hFFFFFFF9, 5'd12, 32'd2,        33);
    run(DIV,    32'h80000000,  32'd2,        5'd13, 32'hC0000000, 33);
    run(REMU,   32'hFFFFFFFF,  32'h10,       5'd14, 32'h0000000F, 33);
    // Early-completion special cases
    run(DIVU,   32'd5,         32'd0,        5'd15, 32'hFFFFFFFF, 1);
    run(REM,    32'd5,         32'd0,        5'd16, 32'd5,        1);
    run(DIV,    32'h80000000,  32'hFFFFFFFF, 5'd17, 32'h80000000, 1);
    run(REM,    32'h80000000,  32'hFFFFFFFF, 5'd18, 32'd0,        1);

    // Flush at iteration 10: no writeback, data held
    @(negedge clk);
    issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd19, 32'h0, 33, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_wb_valid", 32'(wb_valid), 32'd0);
    check("flush_wb_data", wb_data, last_data);
    repeat (40) @(negedge clk);
    check("flush_hold_data", wb_data, last_data);

    // Start while busy is ignored; back-to-back start in the wb_valid cycle
    @(negedge clk);
    issue(DIVU, 32'd1000, 32'd10, 5'd20, 32'd100, 33, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1; funct3 = MUL; rs1_data = 32'd3; rs2_data = 32'd3; rd_in = 5'd31;
    @(negedge clk);
    start = 1'b0;
    for (i = 0; i < 100 && !wb_valid; i++) @(negedge clk);
    check("b2b_wb_seen", 32'(wb_valid), 32'd1);
    issue(MUL, 32'd6, 32'd7, 5'd21, 32'd42, 33, 1'b1);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_idle("b2b");

    // Asynchronous reset mid-CALC
    @(negedge clk);
    issue(MUL, 32'd9, 32'd9, 5'd22, 32'h0, 33, 1'b0);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wb_valid", 32'(wb_valid), 32'd0);
    check("arst_wb_rd", 32'(wb_rd), 32'd0);
    check("arst_wb_data", wb_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_data = 32'h0;
    run(MULH, 32'hFFFFFFFF, 32'd2, 5'd23, 32'hFFFFFFFF, 33);
    run(DIVU, 32'd81, 32'd9, 5'd24, 32'd9, 33);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
